// File: rtl/bcd_seq_adder.sv
// Multi-digit BCD adder. Each operand digit is passed in turn through one external
// 1-digit BCD adder, and the carry ripples from digit 0 upward, one digit per clock.
module bcd_seq_adder #(
  parameter int NDIG = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [4*NDIG-1:0] i_a,
  input  logic [4*NDIG-1:0] i_b,
  input  logic              i_cin,
  output logic [3:0]        o_dig_a,
  output logic [3:0]        o_dig_b,
  output logic              o_dig_cin,
  input  logic [3:0]        i_dig_sum,
  input  logic              i_dig_cout,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [4*NDIG-1:0] o_sum,
  output logic              o_cout
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ADD, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [NDIG-1:0][3:0]  r_a;
  logic [NDIG-1:0][3:0]  r_b;
  logic [NDIG-1:0][3:0]  r_sum;
  logic                  r_cin;
  logic                  r_carry;
  logic                  r_cout;
  logic                  r_err;
  logic [IW-1:0]         r_idx;
  logic                  w_bad;
  logic                  w_last;

  assign w_last = (r_idx == IW'(NDIG - 1));

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (r_a[i] > 4'd9 || r_b[i] > 4'd9) w_bad = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cin   <= 1'b0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a    <= i_a;
            r_b    <= i_b;
            r_cin  <= i_cin;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_err  <= 1'b0;
          end
        end
        S_CHECK: begin
          if (w_bad) begin
            r_err <= 1'b1;
          end else begin
            r_idx   <= '0;
            r_carry <= r_cin;
          end
        end
        S_ADD: begin
          r_sum[r_idx] <= i_dig_sum;
          r_carry      <= i_dig_cout;
          r_idx        <= r_idx + IW'(1);
          if (w_last) r_cout <= i_dig_cout;
        end
        default: ;
      endcase
    end
  end

  // The digit lanes are driven only in ADD; in every other state they read zero.
  always_comb begin
    w_next    = r_state;
    o_dig_a   = 4'd0;
    o_dig_b   = 4'd0;
    o_dig_cin = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_CHECK;
      S_CHECK: w_next = w_bad ? S_DONE : S_ADD;
      S_ADD: begin
        o_dig_a   = r_a[r_idx];
        o_dig_b   = r_b[r_idx];
        o_dig_cin = r_carry;
        if (w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_DONE);
  assign o_err  = r_err;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Directed bench for bcd_seq_adder with NDIG=4. A behavioural 1-digit BCD adder
// sits on the dig_* lanes, and every expected value below was worked out by hand.
module tb_bcd_seq_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        cin;
  logic [3:0]  dig_a;
  logic [3:0]  dig_b;
  logic        dig_cin;
  logic [3:0]  dig_sum;
  logic        dig_cout;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] sum;
  logic        cout;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  bcd_seq_adder #(.NDIG(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a_in), .i_b(b_in), .i_cin(cin),
    .o_dig_a(dig_a), .o_dig_b(dig_b), .o_dig_cin(dig_cin),
    .i_dig_sum(dig_sum), .i_dig_cout(dig_cout),
    .o_busy(busy), .o_done(done), .o_err(err), .o_sum(sum), .o_cout(cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] raw;
  logic [4:0] adj;
  always_comb begin
    raw = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, dig_cin};
    adj = raw + 5'd6;
    if (raw > 5'd9) begin
      dig_sum  = adj[3:0];
      dig_cout = 1'b1;
    end else begin
      dig_sum  = raw[3:0];
      dig_cout = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Pulses start for one edge, then follows the operation until done (at most 20 cycles).
  // lat counts cycles from the accepting edge to the done cycle; lane0 holds the lane
  // values seen one cycle after acceptance.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        output int lat, output int busy_cnt, output logic dig_any,
                        output logic [8:0] lane0);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; busy_cnt = 0; dig_any = 1'b0; lane0 = '0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      if (dig_a != 0 || dig_b != 0 || dig_cin) dig_any = 1'b1;
      if (lat == 1) lane0 = {dig_a, dig_b, dig_cin};
      tick();
      lat++;
    end
    if (busy) busy_cnt++;
  endtask

  int         lat;
  int         bcnt;
  logic       dany;
  logic [8:0] l0;
  int         done_t[$];
  int         t0;

  initial begin
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_flags", {err, cout}, 0);
    check("rst_dig", {dig_a, dig_b, dig_cin}, 0);
    rst_n = 1'b1;
    tick();

    // 1234 + 5678 = 6912
    run_op(16'h1234, 16'h5678, 1'b0, lat, bcnt, dany, l0);
    check("t1_lat", lat, 5);
    check("t1_busy_cycles", bcnt, 6);
    check("t1_lane0", l0, {4'd4, 4'd8, 1'b0});
    check("t1_sum", sum, 16'h6912);
    check("t1_cout_err", {cout, err}, 2'b00);
    tick();
    check("t1_done_pulse", {done, busy}, 2'b00);

    run_op(16'h9999, 16'h0000, 1'b1, lat, bcnt, dany, l0);
    check("t2_sum", sum, 16'h0000);
    check("t2_cout", cout, 1);
    tick();

    run_op(16'h9999, 16'h9999, 1'b1, lat, bcnt, dany, l0);
    check("t3_sum", sum, 16'h9999);
    check("t3_cout", cout, 1);
    tick();

    // non-BCD digit in A
    run_op(16'h12A4, 16'h0001, 1'b0, lat, bcnt, dany, l0);
    check("t4_lat", lat, 1);
    check("t4_err", err, 1);
    check("t4_sum_cout", {sum, cout}, 17'd0);
    check("t4_dig_quiet", dany, 0);
    tick();
    check("t4_err_held", err, 1);

    // A start pulse during ADD is ignored and is not queued.
    a_in = 16'h1111; b_in = 16'h2222; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_err_cleared", err, 0);
    tick(); tick();
    a_in = 16'h3333; b_in = 16'h4444; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin tick(); lat++; end
    check("t5_done_seen", done, 1);
    check("t5_first_sum", sum, 16'h3333);
    tick(); tick();
    check("t5_not_queued", busy, 0);
    run_op(16'h3333, 16'h4444, 1'b0, lat, bcnt, dany, l0);
    check("t5_second_sum", sum, 16'h7777);
    tick();

    // Reset while ADD is on digit 2
    a_in = 16'h4321; b_in = 16'h1111; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("t6_mid_sum", sum, 16'h0032);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_outs", {sum, cout, err, done}, 0);
    check("t6_rst_dig", {dig_a, dig_b, dig_cin}, 0);
    #2 rst_n = 1'b1;
    tick();
    run_op(16'h0005, 16'h0005, 1'b0, lat, bcnt, dany, l0);
    check("t6_after_rst_sum", sum, 16'h0010);
    check("t6_after_rst_lat", lat, 5);
    tick();

    // start held high over three operations
    a_in = 16'h0001; b_in = 16'h0002; cin = 1'b0; start = 1'b1;
    t0 = cycle;
    while (done_t.size() < 3 && cycle - t0 < 60) begin
      tick();
      if (done) done_t.push_back(cycle);
    end
    start = 1'b0;
    check("t7_done_count", done_t.size(), 3);
    if (done_t.size() == 3) begin
      check("t7_gap1", done_t[1] - done_t[0], 7);
      check("t7_gap2", done_t[2] - done_t[1], 7);
    end
    check("t7_sum", sum, 16'h0003);
    repeat (3) tick();
    check("t7_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_seq_adder.md
BCD_SEQ_ADDER -- requirements
Module: bcd_seq_adder

Interface
REQ-001 Parameter NDIG, default 4: number of BCD digits per operand, legal range 1..8.
REQ-002 Clock  in  1  rising-edge clock; the block uses no other clock.
REQ-003 Resetn  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 a_in  in  4*NDIG  operand A, packed BCD, digit 0 in [3:0].
REQ-006 b_in  in  4*NDIG  operand B, same packing as a_in.
REQ-007 cin  in  1  carry into digit 0.
REQ-008 dig_a  out  4  digit A presented to the shared 1-digit BCD adder.
REQ-009 dig_b  out  4  digit B presented to the shared adder.
REQ-010 dig_cin  out  1  carry presented to the shared adder.
REQ-011 dig_sum  in  4  combinational digit sum returned by the shared adder.
REQ-012 dig_cout  in  1  combinational digit carry returned by the shared adder.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 err  out  1  last operation had a non-BCD operand digit; held until next accepted start.
REQ-016 sum  out  4*NDIG  result, packed BCD; held until next accepted start.
REQ-017 cout  out  1  final carry out; held until next accepted start.

Function
REQ-018 FSM states SHALL be IDLE, CHECK, ADD and DONE.
REQ-019 IDLE with start=1: capture a_in, b_in and cin into internal registers; clear sum, cout and err; go to CHECK.
REQ-020 IDLE with start=0: remain in IDLE; all outputs hold.
REQ-021 CHECK, any captured digit >9: set err=1, leave sum=0 and cout=0, go to DONE.
REQ-022 CHECK, all captured digits valid: set digit index=0 and carry=captured cin, go to ADD.
REQ-023 ADD: dig_a, dig_b and dig_cin SHALL equal A[idx], B[idx] and carry, combinationally from registers.
REQ-024 ADD: at each rising edge, sum[idx] <= dig_sum, carry <= dig_cout, idx <= idx+1.
REQ-025 ADD with idx=NDIG-1: after the REQ-024 update, cout <= dig_cout and go to DONE.
REQ-026 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-027 Outside ADD, dig_a, dig_b and dig_cin SHALL be 0.
REQ-028 Latency: start accepted at edge t gives done=1 in the cycle after edge t+NDIG+1 (valid operands) or after edge t+1 (err).
REQ-029 start while busy=1, including in DONE, SHALL be ignored and SHALL NOT be queued.
REQ-030 start held high continuously: a new operation is accepted on the first IDLE cycle after each DONE.
REQ-031 Maximum result is all 9s with cout=1 (e.g. NDIG=4: 9999+9999+1 = 1 9999).
REQ-032 The block SHALL NOT correct or validate dig_sum; the shared adder is trusted.

Reset
REQ-033 Resetn=0 SHALL immediately force IDLE and set busy, done, err, cout, sum, dig_a, dig_b, dig_cin, idx, carry and captured operands to 0, in any state including mid-ADD.
REQ-034 After Resetn deasserts, the first start sampled on a rising edge SHALL be accepted normally.

Verification (NDIG=4, reference 1-digit BCD adder connected to dig_*)
REQ-035 a_in=1234, b_in=5678, cin=0, start pulse -> busy for 6 cycles, done pulse, sum=6912, cout=0, err=0.
REQ-036 a_in=9999, b_in=0000, cin=1 -> sum=0000, cout=1; 9999+9999, cin=1 -> sum=9999, cout=1.
REQ-037 a_in=12A4, b_in=0001 -> done 2 cycles after start, err=1, sum=0000, cout=0, dig_* stay 0.
REQ-038 Second start pulse during ADD with different operands -> ignored; first result is unchanged; a start after done returns to IDLE -> second result is produced.
REQ-039 Resetn pulsed low during ADD (idx=2) -> all outputs 0 immediately, IDLE; then 0005+0005 -> sum=0010.
REQ-040 start held high across three operations -> exactly three done pulses, each separated by NDIG+3 cycles.
